// File: rtl/fnd_pkg.sv
// rtl/fnd_pkg.sv - shared constants and helpers for the FND digit scan controller
package fnd_pkg;

    // Board defaults for a 100 MHz system clock: 1 ms slots, 160 ns dead-time.
    localparam int DEFAULT_SCAN_DIV    = 100_000;
    localparam int DEFAULT_DEAD_CYCLES = 16;

    // Width of the digit position index; never narrower than one bit.
    function automatic int pos_width(input int num_digits);
        return (num_digits <= 2) ? 1 : $clog2(num_digits);
    endfunction

    // Level of an inactive digit enable for the given polarity.
    function automatic logic digit_off(input logic active_low);
        return active_low;
    endfunction

endpackage

// File: rtl/fnd_scan_divider.sv
// rtl/fnd_scan_divider.sv - slot cycle counter and digit position rotation
module fnd_scan_divider #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 16,
    parameter int PW         = 2,
    parameter int KW         = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [KW-1:0] k,
    output logic [KW-1:0] k_next,
    output logic [PW-1:0] pos,
    output logic [PW-1:0] pos_next,
    output logic          tick
);

    localparam logic [KW-1:0] K_LAST = KW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] P_LAST = PW'(NUM_DIGITS - 1);

    // Next slot cycle and position; the position advances only when the slot wraps.
    always_comb begin
        k_next   = k + KW'(1);
        pos_next = pos;
        if (k == K_LAST) begin
            k_next   = '0;
            pos_next = (pos == P_LAST) ? '0 : pos + PW'(1);
        end
    end

    // Counters plus a registered tick that lines up with the last cycle of the slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k    <= '0;
            pos  <= '0;
            tick <= 1'b0;
        end else begin
            k    <= k_next;
            pos  <= pos_next;
            tick <= (k_next == K_LAST);
        end
    end

endmodule

// File: rtl/fnd_digit_scan_ctrl.sv
// rtl/fnd_digit_scan_ctrl.sv - multiplexed FND digit scan with dead-time, blanking and PWM
module fnd_digit_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int SCAN_DIV    = DEFAULT_SCAN_DIV,
    parameter int BRIGHT_W    = 3,
    parameter int DEAD_CYCLES = DEFAULT_DEAD_CYCLES,
    parameter int ACTIVE_LOW  = 1,
    localparam int PW         = pos_width(NUM_DIGITS)
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_enable,
    input  logic [NUM_DIGITS-1:0] i_blank_mask,
    input  logic [BRIGHT_W-1:0]   i_brightness,
    output logic [PW-1:0]         o_digitPosition,
    output logic [NUM_DIGITS-1:0] o_digit,
    output logic                  o_scan_tick
);

    localparam int KW   = $clog2(SCAN_DIV);
    localparam int ON_W = KW + 1;
    localparam int SUB  = SCAN_DIV >> BRIGHT_W;
    localparam logic [NUM_DIGITS-1:0] OFF_VEC = {NUM_DIGITS{digit_off(ACTIVE_LOW != 0)}};

    logic [KW-1:0]         k;
    logic [KW-1:0]         k_next;
    logic [PW-1:0]         pos_next;
    logic [BRIGHT_W-1:0]   held_bright;
    logic                  held_blank;
    logic                  use_live;
    logic [BRIGHT_W-1:0]   bright_eff;
    logic                  blank_eff;
    logic [ON_W-1:0]       on_end;
    logic                  in_window;
    logic                  digit_on;
    logic [NUM_DIGITS-1:0] digit_next;

    fnd_scan_divider #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV),
        .PW         (PW),
        .KW         (KW)
    ) u_divider (
        .clk      (i_clk),
        .rst_n    (i_reset_n),
        .k        (k),
        .k_next   (k_next),
        .pos      (o_digitPosition),
        .pos_next (pos_next),
        .tick     (o_scan_tick)
    );

    // Mask bit and brightness are captured during the first cycle of each slot.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            held_bright <= '0;
            held_blank  <= 1'b0;
        end else if (k == '0) begin
            held_bright <= i_brightness;
            held_blank  <= i_blank_mask[o_digitPosition];
        end
    end

    // Enable for the coming cycle. While the slot-start sample is being taken (and on the
    // edge entering a slot, which only matters with zero dead-time) the live inputs stand in
    // for the held copies so every cycle of a slot sees the same sampled values.
    always_comb begin
        use_live   = (k == '0) || (k_next == '0);
        bright_eff = use_live ? i_brightness : held_bright;
        blank_eff  = use_live ? i_blank_mask[pos_next] : held_blank;
        on_end     = ON_W'((int'(bright_eff) + 1) * SUB);
        in_window  = ({1'b0, k_next} >= ON_W'(DEAD_CYCLES)) && ({1'b0, k_next} < on_end);
        digit_on   = i_enable && !blank_eff && in_window;
        digit_next = OFF_VEC ^ (digit_on ? (NUM_DIGITS'(1) << pos_next) : '0);
    end

    // Registered digit enables so outputs change in step with the position.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_digit <= OFF_VEC;
        end else begin
            o_digit <= digit_next;
        end
    end

endmodule

// File: tb/tb_fnd_digit_scan_ctrl.sv
// tb/tb_fnd_digit_scan_ctrl.sv - randomized self-checking bench for fnd_digit_scan_ctrl
module tb_fnd_digit_scan_ctrl;

    localparam int N    = 4;
    localparam int SD   = 16;
    localparam int BW   = 2;
    localparam int SUB  = 4;
    localparam int DEAD = 1;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b1;
    logic          en     = 1'b0;
    logic [N-1:0]  mask   = '0;
    logic [BW-1:0] bright = '0;
    logic [1:0]    pos_o;
    logic [N-1:0]  dig_o;
    logic          tick_o;

    int checks = 0;
    int errors = 0;

    int n;
    bit en_prev;
    int ref_l;
    bit ref_blank;
    int slot_on;
    int last_slot_on;

    always #5 clk = ~clk;

    fnd_digit_scan_ctrl #(
        .NUM_DIGITS  (N),
        .SCAN_DIV    (SD),
        .BRIGHT_W    (BW),
        .DEAD_CYCLES (DEAD),
        .ACTIVE_LOW  (1)
    ) dut (
        .i_clk           (clk),
        .i_reset_n       (rst_n),
        .i_enable        (en),
        .i_blank_mask    (mask),
        .i_brightness    (bright),
        .o_digitPosition (pos_o),
        .o_digit         (dig_o),
        .o_scan_tick     (tick_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, n, got, exp);
        end
    endtask

    // Reference: n cycles since reset release; slot cycle and position by plain arithmetic.
    function automatic logic [N-1:0] exp_digit();
        int k = n % SD;
        int p = (n / SD) % N;
        logic [N-1:0] v = {N{1'b1}};
        if (en_prev && !ref_blank && k >= DEAD && k < (ref_l + 1) * SUB)
            v[p] = 1'b0;
        return v;
    endfunction

    task automatic check_outputs();
        check("pos", 32'(pos_o), 32'((n / SD) % N));
        check("tick", 32'(tick_o), 32'((n % SD) == SD - 1));
        check("digit", 32'(dig_o), 32'(exp_digit()));
    endtask

    // Record the inputs applied during cycle n, then advance to cycle n+1 and check it.
    task automatic step();
        if (n % SD == 0) begin
            ref_l     = int'(bright);
            ref_blank = mask[(n / SD) % N];
        end
        en_prev = en;
        @(negedge clk);
        n++;
        if (n % SD == 0) slot_on = 0;
        if (dig_o != {N{1'b1}}) slot_on++;
        if (n % SD == SD - 1) last_slot_on = slot_on;
        check_outputs();
    endtask

    task automatic run_until(input int p, input int kk);
        for (int i = 0; i < 2 * SD * N && !(((n / SD) % N) == p && (n % SD) == kk); i++)
            step();
    endtask

    // Asynchronous reset between clock edges; outputs must clear without a clock.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_pos", 32'(pos_o), 32'd0);
        check("rst_tick", 32'(tick_o), 32'd0);
        check("rst_digit", 32'(dig_o), 32'hf);
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        n       = 0;
        en_prev = 1'b0;
        slot_on = 0;
        #1;
        check_outputs();
    endtask

    initial begin
        n = 0;
        en_prev = 1'b0;
        ref_l = 0;
        ref_blank = 1'b0;
        slot_on = 0;
        last_slot_on = 0;
        do_reset();

        en = 1'b1; mask = '0; bright = 2'd3;
        repeat (5 * SD) step();
        bright = 2'd0;
        repeat (4 * SD) step();
        bright = 2'd1;
        repeat (4 * SD) step();
        bright = 2'd3; mask = 4'b0100;
        repeat (4 * SD) step();

        mask = '0;
        run_until(1, 8);
        bright = 2'd0;
        run_until(2, 0);
        check("slot1_on", 32'(last_slot_on), 32'd15);
        run_until(3, 0);
        check("slot2_on", 32'(last_slot_on), 32'd3);

        bright = 2'd3;
        run_until(0, 5);
        en = 1'b0;
        run_until(0, 9);
        en = 1'b1;
        run_until(1, 0);
        check("en_gap_on", 32'(last_slot_on), 32'd11);

        repeat (1500) begin
            if ($urandom_range(0, 7) == 0)  en = 1'($urandom);
            if ($urandom_range(0, 15) == 0) mask = N'($urandom);
            if ($urandom_range(0, 15) == 0) bright = BW'($urandom);
            step();
        end

        en = 1'b1; mask = '0; bright = 2'd3;
        run_until(2, 6);
        do_reset();
        repeat (2 * SD) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
